// File: rtl/alu_operand_stage_if.sv
// Decode-side, forwarding-source and ALU-side signals of the ID/EX operand stage.
// The master drives the stage inputs and observes its outputs.
interface alu_operand_stage_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [REG_AW-1:0] rn_addr;
    logic [REG_AW-1:0] rm_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [2:0]        alu_op_in;
    logic              reg_write_in;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        ALUOp;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              valid_out;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output stall, flush, in_valid, rd1_data, rd2_data, imm, alu_src,
               rn_addr, rm_addr, rd_addr, alu_op_in, reg_write_in,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  A, B, ALUOp, store_data, rd_out, reg_write_out, valid_out,
               fwd_a, fwd_b
    );

    modport slave (
        input  stall, flush, in_valid, rd1_data, rd2_data, imm, alu_src,
               rn_addr, rm_addr, rd_addr, alu_op_in, reg_write_in,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output A, B, ALUOp, store_data, rd_out, reg_write_out, valid_out,
               fwd_a, fwd_b
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Operand outputs are combinational from the register bank plus live forwarding sources.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned ZR_IDX = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_operand_stage_if.slave   bus
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZR_IDX);

    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic [REG_AW-1:0] rn_q;
    logic [REG_AW-1:0] rm_q;
    logic [REG_AW-1:0] rd_q;
    logic [2:0]        alu_op_q;
    logic              reg_write_q;
    logic              valid_q;

    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] fwd_rm;

    // Reset and flush both empty the slot; flush takes precedence over stall.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            alu_op_q    <= 3'b000;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
        end else if (!bus.stall) begin
            rd1_q       <= bus.rd1_data;
            rd2_q       <= bus.rd2_data;
            imm_q       <= bus.imm;
            alu_src_q   <= bus.alu_src;
            rn_q        <= bus.rn_addr;
            rm_q        <= bus.rm_addr;
            rd_q        <= bus.rd_addr;
            alu_op_q    <= bus.alu_op_in;
            reg_write_q <= bus.reg_write_in & bus.in_valid;
            valid_q     <= bus.in_valid;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; XZR is never a forwarding target.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (bus.exmem_reg_write && (bus.exmem_rd != ZR) && (bus.exmem_rd == rn_q))
            sel_a = 2'b10;
        else if (bus.memwb_reg_write && (bus.memwb_rd != ZR) && (bus.memwb_rd == rn_q))
            sel_a = 2'b01;
        if (bus.exmem_reg_write && (bus.exmem_rd != ZR) && (bus.exmem_rd == rm_q))
            sel_b = 2'b10;
        else if (bus.memwb_reg_write && (bus.memwb_rd != ZR) && (bus.memwb_rd == rm_q))
            sel_b = 2'b01;

        a_val  = rd1_q;
        fwd_rm = rd2_q;
        case (sel_a)
            2'b10:   a_val = bus.exmem_result;
            2'b01:   a_val = bus.memwb_result;
            default: a_val = rd1_q;
        endcase
        case (sel_b)
            2'b10:   fwd_rm = bus.exmem_result;
            2'b01:   fwd_rm = bus.memwb_result;
            default: fwd_rm = rd2_q;
        endcase
        if (rn_q == ZR) a_val  = '0;
        if (rm_q == ZR) fwd_rm = '0;
    end

    assign bus.A             = a_val;
    assign bus.B             = alu_src_q ? imm_q : fwd_rm;
    assign bus.store_data    = fwd_rm;
    assign bus.ALUOp         = alu_op_q;
    assign bus.rd_out        = rd_q;
    assign bus.reg_write_out = reg_write_q;
    assign bus.valid_out     = valid_q;
    assign bus.fwd_a         = sel_a;
    assign bus.fwd_b         = sel_b;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed vector table plus hand-written reset/stall/flush sequences for alu_operand_stage.
module tb_alu_operand_stage;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  alu_op;
        logic [63:0] store_data;
        logic [4:0]  rd_out;
        logic        reg_write_out;
        logic        valid_out;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
    } out_t;

    typedef struct packed {
        logic        in_valid;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic        alu_src;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        rw;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic [63:0] ex_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [63:0] wb_res;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    alu_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    alu_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZR_IDX(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input vec_t v);
        bus.in_valid        = v.in_valid;
        bus.rd1_data        = v.rd1;
        bus.rd2_data        = v.rd2;
        bus.imm             = v.imm;
        bus.alu_src         = v.alu_src;
        bus.rn_addr         = v.rn;
        bus.rm_addr         = v.rm;
        bus.rd_addr         = v.rd;
        bus.alu_op_in       = v.op;
        bus.reg_write_in    = v.rw;
        bus.exmem_reg_write = v.ex_rw;
        bus.exmem_rd        = v.ex_rd;
        bus.exmem_result    = v.ex_res;
        bus.memwb_reg_write = v.wb_rw;
        bus.memwb_rd        = v.wb_rd;
        bus.memwb_result    = v.wb_res;
    endtask

    task automatic check(input string name, input out_t want);
        out_t got;
        got = '{bus.A, bus.B, bus.ALUOp, bus.store_data, bus.rd_out,
                bus.reg_write_out, bus.valid_out, bus.fwd_a, bus.fwd_b};
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got A=%h B=%h op=%b sd=%h rd=%0d rw=%b v=%b fa=%b fb=%b want A=%h B=%h op=%b sd=%h rd=%0d rw=%b v=%b fa=%b fb=%b",
                     name, got.a, got.b, got.alu_op, got.store_data, got.rd_out,
                     got.reg_write_out, got.valid_out, got.fwd_a, got.fwd_b,
                     want.a, want.b, want.alu_op, want.store_data, want.rd_out,
                     want.reg_write_out, want.valid_out, want.fwd_a, want.fwd_b);
        end
    endtask

    vec_t vecs[9];
    vec_t vx;
    vec_t vnz;
    out_t e;

    initial begin
        // in_valid rd1 rd2 imm alu_src rn rm rd op rw | ex_rw ex_rd ex_res | wb_rw wb_rd wb_res | expected
        vecs[0] = '{1'b1, 64'h5, 64'h3, 64'h0, 1'b0, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    '{64'h5, 64'h3, 3'b010, 64'h3, 5'd3, 1'b1, 1'b1, 2'b00, 2'b00}};
        vecs[1] = '{1'b1, 64'h11, 64'h22, 64'h0, 1'b0, 5'd4, 5'd4, 5'd5, 3'b001, 1'b1,
                    1'b1, 5'd4, 64'hAA, 1'b1, 5'd4, 64'hBB,
                    '{64'hAA, 64'hAA, 3'b001, 64'hAA, 5'd5, 1'b1, 1'b1, 2'b10, 2'b10}};
        vecs[2] = '{1'b1, 64'h11, 64'h22, 64'h0, 1'b0, 5'd4, 5'd4, 5'd5, 3'b001, 1'b1,
                    1'b0, 5'd4, 64'hAA, 1'b1, 5'd4, 64'hBB,
                    '{64'hBB, 64'hBB, 3'b001, 64'hBB, 5'd5, 1'b1, 1'b1, 2'b01, 2'b01}};
        vecs[3] = '{1'b1, 64'hFFFF, 64'h3, 64'h10, 1'b1, 5'd31, 5'd2, 5'd6, 3'b100, 1'b1,
                    1'b1, 5'd31, 64'h55, 1'b0, 5'd0, 64'h0,
                    '{64'h0, 64'h10, 3'b100, 64'h3, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00}};
        vecs[4] = '{1'b1, 64'h9, 64'h3, 64'h10, 1'b1, 5'd1, 5'd2, 5'd7, 3'b011, 1'b1,
                    1'b1, 5'd2, 64'h77, 1'b0, 5'd0, 64'h0,
                    '{64'h9, 64'h10, 3'b011, 64'h77, 5'd7, 1'b1, 1'b1, 2'b00, 2'b10}};
        vecs[5] = '{1'b0, 64'h7, 64'h8, 64'h0, 1'b0, 5'd5, 5'd6, 5'd9, 3'b011, 1'b1,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    '{64'h7, 64'h8, 3'b011, 64'h8, 5'd9, 1'b0, 1'b0, 2'b00, 2'b00}};
        vecs[6] = '{1'b1, 64'h1, 64'h44, 64'h0, 1'b0, 5'd3, 5'd31, 5'd8, 3'b111, 1'b1,
                    1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'h99,
                    '{64'h1, 64'h0, 3'b111, 64'h0, 5'd8, 1'b1, 1'b1, 2'b00, 2'b00}};
        vecs[7] = '{1'b1, 64'h1, 64'h2, 64'h0, 1'b0, 5'd6, 5'd7, 5'd11, 3'b010, 1'b1,
                    1'b1, 5'd7, 64'hCC, 1'b1, 5'd6, 64'hDD,
                    '{64'hDD, 64'hCC, 3'b010, 64'hCC, 5'd11, 1'b1, 1'b1, 2'b01, 2'b10}};
        vecs[8] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 64'h0, 1'b0,
                    5'd12, 5'd13, 5'd14, 3'b110, 1'b0,
                    1'b0, 5'd12, 64'h1, 1'b0, 5'd13, 64'h2,
                    '{64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 3'b110,
                      64'hFEDC_BA98_7654_3210, 5'd14, 1'b0, 1'b1, 2'b00, 2'b00}};
        vx      = '{1'b1, 64'hA1, 64'hB2, 64'h0, 1'b0, 5'd8, 5'd9, 5'd10, 3'b101, 1'b1,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    '{64'hA1, 64'hB2, 3'b101, 64'hB2, 5'd10, 1'b1, 1'b1, 2'b00, 2'b00}};
        // Nonzero decode inputs with forwarding disabled.
        vnz     = '{1'b1, 64'hDEAD, 64'hBEEF, 64'h1234, 1'b1, 5'd17, 5'd18, 5'd19, 3'b111, 1'b1,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, '0};

        // Reset for two cycles with nonzero inputs.
        reset     = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b0;
        drive(vnz);
        @(posedge clk); #1;
        check("reset_cycle1", '0);
        @(posedge clk); #1;
        check("reset_cycle2", '0);

        @(negedge clk);
        reset     = 1'b0;
        bus.stall = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load X, then stall three cycles with changing inputs.
        @(negedge clk);
        drive(vx);
        @(posedge clk); #1;
        check("stall_load", vx.exp);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.stall = 1'b1;
            drive(vecs[k % 2 == 0 ? 0 : 5]);
            e = vx.exp;
            if (k == 2) begin
                bus.exmem_reg_write = 1'b1;
                bus.exmem_rd        = 5'd8;
                bus.exmem_result    = 64'hEE;
                e.a                 = 64'hEE;
                e.fwd_a             = 2'b10;
            end
            @(posedge clk); #1;
            check($sformatf("stall_hold%0d", k), e);
        end

        // Stall and flush together: bubble.
        @(negedge clk);
        drive(vnz);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        check("stall_flush", '0);

        // Flush alone after a real load.
        @(negedge clk);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(vx);
        @(posedge clk); #1;
        check("reload", vx.exp);
        @(negedge clk);
        drive(vnz);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        check("flush_only", '0);

        // Reset asserted mid-stall clears state; first load after release.
        @(negedge clk);
        bus.flush = 1'b0;
        drive(vx);
        @(posedge clk); #1;
        check("pre_reset_load", vx.exp);
        @(negedge clk);
        drive(vnz);
        bus.stall = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_stall", '0);
        @(negedge clk);
        reset     = 1'b0;
        bus.stall = 1'b0;
        drive(vecs[0]);
        @(posedge clk); #1;
        check("first_load_after_reset", vecs[0].exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage ARMv8 core.
- Drives the ALU's A, B and ALUOp inputs, and carries store data and writeback control down the pipe.
- Resolves RAW hazards by bypassing results from EX/MEM and MEM/WB.
- Handles stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DATA_W, 64, operand/result width
- REG_AW, 5, register address width
- ZR_IDX, 31, register index treated as XZR (never forwarded, reads as zero)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- stall  in  1  hold ID/EX contents this cycle
- flush  in  1  load bubble into ID/EX this cycle
- in_valid  in  1  decode stage presents a real instruction
- rd1_data  in  DATA_W  register file read port 1 (Rn)
- rd2_data  in  DATA_W  register file read port 2 (Rm/Rt)
- imm  in  DATA_W  sign-extended immediate
- alu_src  in  1  1: B takes imm; 0: B takes Rm
- rn_addr, rm_addr, rd_addr  in  REG_AW each  source/destination indices
- alu_op_in  in  3  ALU operation code from control
- reg_write_in  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM stage will write back
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB stage will write back
- memwb_rd  in  REG_AW  MEM/WB destination
- memwb_result  in  DATA_W  MEM/WB writeback value
- A  out  DATA_W  ALU operand A
- B  out  DATA_W  ALU operand B
- ALUOp  out  3  registered alu_op_in
- store_data  out  DATA_W  forwarded Rm value for stores
- rd_out  out  REG_AW  registered rd_addr
- reg_write_out  out  1  registered reg_write_in AND valid
- valid_out  out  1  EX stage holds a real instruction
- fwd_a, fwd_b  out  2  mux selects: 00 regfile, 10 EX/MEM, 01 MEM/WB (debug/verification)

Behaviour:
- Register: one bank (suffix _q) holds rd1, rd2, imm, alu_src, rn, rm, rd, alu_op, reg_write, valid. All are updated on rising clk only.
- Priority per edge: reset > flush > stall > load.
  - reset: every _q field cleared to 0.
  - flush: valid_q=0, reg_write_q=0, alu_op_q=000, all data/addr fields 0. Flush wins over a simultaneous stall.
  - stall (no flush): all _q fields hold.
  - load: capture inputs; valid_q=in_valid; reg_write_q=reg_write_in & in_valid.
- Latency: inputs appear at the ALU exactly 1 cycle after capture. Forwarding is combinational from _q fields plus the live exmem_*/memwb_* inputs in the same cycle.
- Forward A:
  - if exmem_reg_write & exmem_rd!=ZR_IDX & exmem_rd==rn_q → exmem_result (fwd_a=10)
  - else if memwb_reg_write & memwb_rd!=ZR_IDX & memwb_rd==rn_q → memwb_result (fwd_a=01)
  - else rd1_q (fwd_a=00)
- Forward B: same rules against rm_q, producing fwd_rm; fwd_b reports the select.
- XZR: if rn_q==ZR_IDX, A=0 regardless of rd1_q. If rm_q==ZR_IDX, fwd_rm=0.
- B = alu_src_q ? imm_q : fwd_rm. fwd_b is still reported when alu_src_q=1.
- store_data = fwd_rm always.
- ALUOp = alu_op_q, rd_out = rd_q, reg_write_out = reg_write_q, valid_out = valid_q.
- Reset values: A=0, B=0, ALUOp=000, store_data=0, rd_out=0, reg_write_out=0, valid_out=0, fwd_a=fwd_b=00. These hold as long as no forwarding source matches rn/rm=0 during reset; the bench drives exmem/memwb_reg_write=0 while reset is asserted.
- During a stall, forwarded values track the live exmem/memwb inputs every cycle; only the register holds.
- Reset asserted mid-stall or mid-flush clears state on the next edge. The first load happens on the first edge after reset deasserts.
- Outputs are unsigned bit vectors; no arithmetic is performed here.

Test Plan:
- Reset: hold reset 2 cycles with inputs nonzero → all outputs 0, valid_out=0.
- Plain load: rd1=0x5, rd2=0x3, rn=1, rm=2, alu_src=0, alu_op_in=010, in_valid=1, no forwarding → next cycle A=0x5, B=0x3, ALUOp=010, fwd_a=fwd_b=00, valid_out=1.
- Double hazard: rn_q=rm_q=4; exmem_rd=4 with exmem_result=0xAA; memwb_rd=4 with memwb_result=0xBB; both write enables 1 → A=B=0xAA, fwd=10. Drop exmem_reg_write → A=B=0xBB, fwd=01.
- XZR and immediate: rn=31, rd1=0xFFFF, exmem_rd=31, exmem_reg_write=1 → A=0, fwd_a=00. With alu_src=1, imm=0x10, rm=2, exmem_rd=2, exmem_result=0x77 → B=0x10, store_data=0x77.
- Stall then flush: load instruction X, stall 3 cycles while changing inputs → A/B/ALUOp unchanged. Assert stall and flush together → next cycle valid_out=0, reg_write_out=0, ALUOp=000.
- Bubble input: in_valid=0 with reg_write_in=1 → reg_write_out=0, valid_out=0.
